// File: rtl/sensor_pkt_pkg.sv
// Shared types and constants for the sensor snapshot path between the BNO085
// controller and the MCU SPI slave.
package sensor_pkt_pkg;

  typedef struct packed {
    logic signed [15:0] w;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } quat_t;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } gyro_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GATHER  = 2'd1,
    ST_PRESENT = 2'd2,
    ST_HOLDOFF = 2'd3
  } sched_state_t;

  localparam logic [7:0] PKT_HEADER = 8'hAA;
  localparam int         PKT_BYTES  = 16;

  // Adds up to two drop events in one cycle and pins the result at 255.
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'b0, inc};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Synchronizes an asynchronous level into clk and emits a one-cycle pulse on
// its rising edge.
module sync_rise_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_sig,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | STAGES'(async_sig);
      last_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/sensor_snapshot_scheduler.sv
// Pairs quaternion/gyro updates into a frozen snapshot, presents it with done
// to the MCU and retires it on a synchronized load edge or on timeout.
module sensor_snapshot_scheduler
  import sensor_pkt_pkg::*;
#(
  parameter int GATHER_CYCLES  = 1000,
  parameter int ACK_TIMEOUT    = 3_000_000,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        quat_valid_in,
  input  logic [15:0] quat_w_in,
  input  logic [15:0] quat_x_in,
  input  logic [15:0] quat_y_in,
  input  logic [15:0] quat_z_in,
  input  logic        gyro_valid_in,
  input  logic [15:0] gyro_x_in,
  input  logic [15:0] gyro_y_in,
  input  logic [15:0] gyro_z_in,
  input  logic        load,
  output logic [15:0] snap_quat_w,
  output logic [15:0] snap_quat_x,
  output logic [15:0] snap_quat_y,
  output logic [15:0] snap_quat_z,
  output logic [15:0] snap_gyro_x,
  output logic [15:0] snap_gyro_y,
  output logic [15:0] snap_gyro_z,
  output logic        snap_quat_valid,
  output logic        snap_gyro_valid,
  output logic        done,
  output logic [7:0]  seq,
  output logic [7:0]  drop_cnt,
  output logic        timeout_flag
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] GATHER  = ST_GATHER;
  localparam logic [1:0] PRESENT = ST_PRESENT;
  localparam logic [1:0] HOLDOFF = ST_HOLDOFF;

  localparam logic [31:0] GATHER_LAST  = 32'(GATHER_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0] HOLDOFF_LAST = 32'(HOLDOFF_CYCLES - 1);

  logic [1:0]  state;
  logic [31:0] cnt;
  logic        pend_q, pend_g;
  quat_t       pend_quat, snap_quat;
  gyro_t       pend_gyro, snap_gyro;
  logic        load_rise;
  logic        go_present;
  logic        drop_q, drop_g;

  sync_rise_detect #(.STAGES(SYNC_STAGES)) u_load_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_sig (load),
    .rise      (load_rise)
  );

  // A pulse that lands on the transfer cycle refills a flag being emptied, so it is not a drop.
  always_comb begin
    go_present = 1'b0;
    if (state == IDLE)
      go_present = pend_q & pend_g;
    else if (state == GATHER)
      go_present = (pend_q & pend_g) | (cnt == GATHER_LAST);
    drop_q = quat_valid_in & pend_q & ~go_present;
    drop_g = gyro_valid_in & pend_g & ~go_present;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pend_q       <= 1'b0;
      pend_g       <= 1'b0;
      pend_quat    <= '0;
      pend_gyro    <= '0;
      snap_quat    <= '0;
      snap_gyro    <= '0;
      snap_quat_valid <= 1'b0;
      snap_gyro_valid <= 1'b0;
      done         <= 1'b0;
      seq          <= '0;
      drop_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (quat_valid_in) begin
        pend_quat <= '{w: quat_w_in, x: quat_x_in, y: quat_y_in, z: quat_z_in};
        pend_q    <= 1'b1;
      end else if (go_present) begin
        pend_q <= 1'b0;
      end
      if (gyro_valid_in) begin
        pend_gyro <= '{x: gyro_x_in, y: gyro_y_in, z: gyro_z_in};
        pend_g    <= 1'b1;
      end else if (go_present) begin
        pend_g <= 1'b0;
      end
      drop_cnt <= sat_add8(drop_cnt, {1'b0, drop_q} + {1'b0, drop_g});

      if (go_present) begin
        state <= PRESENT;
        cnt   <= '0;
        done  <= 1'b1;
        seq   <= seq + 8'd1;
        if (pend_q) snap_quat <= pend_quat;
        if (pend_g) snap_gyro <= pend_gyro;
        snap_quat_valid <= pend_q;
        snap_gyro_valid <= pend_g;
      end else begin
        case (state)
          IDLE: begin
            if (pend_q | pend_g) begin
              state <= GATHER;
              cnt   <= '0;
            end
          end
          GATHER: cnt <= cnt + 32'd1;
          PRESENT: begin
            if (load_rise) begin
              state        <= HOLDOFF;
              cnt          <= '0;
              done         <= 1'b0;
              timeout_flag <= 1'b0;
            end else if (ACK_TIMEOUT != 0 && cnt == TIMEOUT_LAST) begin
              state        <= HOLDOFF;
              cnt          <= '0;
              done         <= 1'b0;
              timeout_flag <= 1'b1;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          default: begin
            if (cnt == HOLDOFF_LAST) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
        endcase
      end
    end
  end

  assign snap_quat_w = snap_quat.w;
  assign snap_quat_x = snap_quat.x;
  assign snap_quat_y = snap_quat.y;
  assign snap_quat_z = snap_quat.z;
  assign snap_gyro_x = snap_gyro.x;
  assign snap_gyro_y = snap_gyro.y;
  assign snap_gyro_z = snap_gyro.z;

endmodule

// File: tb/tb_sensor_snapshot_scheduler.sv
// Directed bench for sensor_snapshot_scheduler with short gather, timeout and
// holdoff windows so every path is reached in a few hundred cycles.
module tb_sensor_snapshot_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        quat_valid_in, gyro_valid_in, load;
  logic [15:0] quat_w_in, quat_x_in, quat_y_in, quat_z_in;
  logic [15:0] gyro_x_in, gyro_y_in, gyro_z_in;
  logic [15:0] snap_quat_w, snap_quat_x, snap_quat_y, snap_quat_z;
  logic [15:0] snap_gyro_x, snap_gyro_y, snap_gyro_z;
  logic        snap_quat_valid, snap_gyro_valid, done, timeout_flag;
  logic [7:0]  seq, drop_cnt;

  int total = 0;
  int bad   = 0;
  int n;

  sensor_snapshot_scheduler #(
    .GATHER_CYCLES(8), .ACK_TIMEOUT(50), .HOLDOFF_CYCLES(4), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .quat_valid_in(quat_valid_in), .quat_w_in(quat_w_in), .quat_x_in(quat_x_in),
    .quat_y_in(quat_y_in), .quat_z_in(quat_z_in),
    .gyro_valid_in(gyro_valid_in), .gyro_x_in(gyro_x_in), .gyro_y_in(gyro_y_in),
    .gyro_z_in(gyro_z_in), .load(load),
    .snap_quat_w(snap_quat_w), .snap_quat_x(snap_quat_x), .snap_quat_y(snap_quat_y),
    .snap_quat_z(snap_quat_z), .snap_gyro_x(snap_gyro_x), .snap_gyro_y(snap_gyro_y),
    .snap_gyro_z(snap_gyro_z), .snap_quat_valid(snap_quat_valid),
    .snap_gyro_valid(snap_gyro_valid), .done(done), .seq(seq), .drop_cnt(drop_cnt),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic qv, input logic [15:0] qw,
                               input logic gv, input logic [15:0] gx);
    quat_valid_in = qv;
    quat_w_in = qw;
    quat_x_in = qw + 16'd1;
    quat_y_in = qw + 16'd2;
    quat_z_in = qw + 16'd3;
    gyro_valid_in = gv;
    gyro_x_in = gx;
    gyro_y_in = gx - 16'd1;
    gyro_z_in = gx - 16'd2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic waitDone(input logic level, input int limit, input string tag);
    int k;
    k = 0;
    while (done !== level && k < limit) begin
      step();
      k++;
    end
    checkOutput(tag, {31'd0, done}, {31'd0, level});
  endtask

  task automatic doSnapshot(input logic [15:0] qw);
    applyStimulus(1'b1, qw, 1'b1, ~qw);
    step();
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    waitDone(1'b1, 40, "loop_done_rise");
    load = 1'b1;
    waitDone(1'b0, 10, "loop_done_fall");
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    step();
    step();
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_seq", {24'd0, seq}, 32'd0);
    checkOutput("rst_drop", {24'd0, drop_cnt}, 32'd0);
    checkOutput("rst_qvalid", {31'd0, snap_quat_valid}, 32'd0);
    checkOutput("rst_snap_w", {16'd0, snap_quat_w}, 32'd0);
    rst_n = 1'b1;
    step();

    // paired update
    applyStimulus(1'b1, 16'h4000, 1'b1, 16'hFFFB);
    step();
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    checkOutput("t1_done_t1", {31'd0, done}, 32'd0);
    step();
    checkOutput("t1_done_t2", {31'd0, done}, 32'd1);
    checkOutput("t1_snap_w", {16'd0, snap_quat_w}, 32'h4000);
    checkOutput("t1_snap_qz", {16'd0, snap_quat_z}, 32'h4003);
    checkOutput("t1_snap_gx", {16'd0, snap_gyro_x}, 32'hFFFB);
    checkOutput("t1_snap_gz", {16'd0, snap_gyro_z}, 32'hFFF9);
    checkOutput("t1_valids", {30'd0, snap_quat_valid, snap_gyro_valid}, 32'd3);
    checkOutput("t1_seq", {24'd0, seq}, 32'd1);
    load = 1'b1;
    step();
    step();
    checkOutput("t1_done_c2", {31'd0, done}, 32'd1);
    step();
    checkOutput("t1_done_c3", {31'd0, done}, 32'd0);
    load = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // unpaired quaternion
    applyStimulus(1'b1, 16'h1234, 1'b0, 16'h0);
    step();
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) step();
    checkOutput("t2_done_t9", {31'd0, done}, 32'd0);
    step();
    checkOutput("t2_done_t10", {31'd0, done}, 32'd1);
    checkOutput("t2_valids", {30'd0, snap_quat_valid, snap_gyro_valid}, 32'd2);
    checkOutput("t2_snap_w", {16'd0, snap_quat_w}, 32'h1234);
    checkOutput("t2_gyro_kept", {16'd0, snap_gyro_x}, 32'hFFFB);
    checkOutput("t2_seq", {24'd0, seq}, 32'd2);

    // overwrites while presenting
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0, 16'h0);
      step();
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    checkOutput("t3_drop", {24'd0, drop_cnt}, 32'd2);
    checkOutput("t3_frozen", {16'd0, snap_quat_w}, 32'h1234);
    checkOutput("t3_still_done", {31'd0, done}, 32'd1);
    load = 1'b1;
    step();
    step();
    step();
    checkOutput("t3_ack", {31'd0, done}, 32'd0);
    load = 1'b0;
    waitDone(1'b1, 40, "t3_next_done");
    checkOutput("t3_next_w", {16'd0, snap_quat_w}, 32'h3);
    checkOutput("t3_next_seq", {24'd0, seq}, 32'd3);
    checkOutput("t3_next_gvalid", {31'd0, snap_gyro_valid}, 32'd0);

    // acknowledge timeout
    n = 0;
    while (done === 1'b1 && n < 200) begin
      n++;
      step();
    end
    checkOutput("t4_done_width", 32'(n), 32'd50);
    checkOutput("t4_tflag_set", {31'd0, timeout_flag}, 32'd1);
    applyStimulus(1'b1, 16'h0777, 1'b1, 16'h0010);
    step();
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    waitDone(1'b1, 40, "t4_next_done");
    checkOutput("t4_tflag_held", {31'd0, timeout_flag}, 32'd1);
    checkOutput("t4_seq", {24'd0, seq}, 32'd4);
    load = 1'b1;
    waitDone(1'b0, 10, "t4_ack");
    load = 1'b0;
    checkOutput("t4_tflag_clr", {31'd0, timeout_flag}, 32'd0);

    // drop counter saturation
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b0, 16'h0);
      step();
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    checkOutput("t5_drop_sat", {24'd0, drop_cnt}, 32'd255);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 16'h00AA, 1'b1, 16'h00BB);
      step();
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    checkOutput("t5_drop_hold", {24'd0, drop_cnt}, 32'd255);

    // asynchronous reset while presenting
    waitDone(1'b1, 120, "t6_present");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_done_async", {31'd0, done}, 32'd0);
    checkOutput("t6_seq_async", {24'd0, seq}, 32'd0);
    checkOutput("t6_flags_async", {29'd0, snap_quat_valid, snap_gyro_valid, timeout_flag}, 32'd0);
    checkOutput("t6_drop_async", {24'd0, drop_cnt}, 32'd0);
    #3;
    rst_n = 1'b1;
    step();
    load = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checkOutput("t6_load_idle_done", {31'd0, done}, 32'd0);
    checkOutput("t6_load_idle_seq", {24'd0, seq}, 32'd0);
    load = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // sequence wrap
    for (int i = 0; i < 257; i++) doSnapshot(16'(i));
    checkOutput("t5_seq_wrap", {24'd0, seq}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sensor_snapshot_scheduler.md
# sensor_snapshot_scheduler

- Sits between the BNO085 controller and `mcu_spi_slave`.
- Captures one-cycle quaternion/gyro valid pulses into a pending stage and pairs them within a gather window.
- Presents a frozen snapshot plus `done` to the SPI slave and MCU, then retires it on the MCU `load` acknowledge or on timeout.
- Sequences the done/load handshake, counts overwritten (dropped) updates and tags each snapshot with a sequence number.

## Interface
Parameters:
- `GATHER_CYCLES`, 1000: max cycles to wait for the second data type after the first arrives.
- `ACK_TIMEOUT`, 3_000_000: cycles in PRESENT before forced retire; 0 disables the timeout.
- `HOLDOFF_CYCLES`, 16: minimum gap between a retire and the next presentation; must be ≥1.
- `SYNC_STAGES`, 2: synchronizer depth for `load`.

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1: system clock.
- `rst_n` in 1: async active-low reset.
- `quat_valid_in` in 1: one-cycle pulse.
- `quat_w_in`, `quat_x_in`, `quat_y_in`, `quat_z_in` in 16 each: signed quaternion.
- `gyro_valid_in` in 1: one-cycle pulse.
- `gyro_x_in`, `gyro_y_in`, `gyro_z_in` in 16 each: signed gyro.
- `load` in 1: MCU acknowledge; asynchronous to `clk`.
- `snap_quat_w/x/y/z` out 16 each: snapshot quaternion.
- `snap_gyro_x/y/z` out 16 each: snapshot gyro.
- `snap_quat_valid`, `snap_gyro_valid` out 1: snapshot flags; feed the SPI slave's valid inputs.
- `done` out 1: snapshot ready for MCU.
- `seq` out 8: snapshot sequence number; wraps 255→0.
- `drop_cnt` out 8: overwritten pending updates; saturates at 255.
- `timeout_flag` out 1: last snapshot retired by timeout.

## Operation
- Pending stage, per type: a data register plus a `pend_q` / `pend_g` flag.
  - A valid pulse captures its data and sets its flag, in any state.
  - If the flag was already set, `drop_cnt` increments (saturating).
  - Same-cycle quat and gyro pulses capture both.
- States: IDLE, GATHER, PRESENT, HOLDOFF.
- IDLE:
  - `pend_q & pend_g` → PRESENT.
  - Otherwise, either flag set → GATHER with the gather counter cleared.
- GATHER:
  - Both flags set, or counter = `GATHER_CYCLES-1` → PRESENT.
  - Otherwise increment the counter.
- Transfer on every entry to PRESENT:
  - Copy the pending data of each set flag into the snapshot.
  - `snap_*_valid` = pending flags; data of an unset type keeps its previous value.
  - Clear the transferred pending flags. A valid pulse on the transfer cycle re-sets the flag with the new data, and this is not counted as a drop.
  - `seq` increments.
  - Timeout counter cleared.
- PRESENT:
  - `done` = 1; snapshot and flags are frozen.
  - Synchronized `load` rising edge → HOLDOFF; clear `timeout_flag`.
  - Else if `ACK_TIMEOUT` ≠ 0 and counter = `ACK_TIMEOUT-1` → HOLDOFF; set `timeout_flag`.
  - A `load` edge and the timeout on the same cycle: the `load` edge wins.
- HOLDOFF:
  - `done` = 0; snapshot still held.
  - After `HOLDOFF_CYCLES` cycles → IDLE.
  - Pending data accumulates meanwhile.
- Snapshot changes only on PRESENT entry; the SPI slave can be clocked at any time without tearing.
- `load` edges outside PRESENT are ignored.

## Timing
- Reset values (asynchronous): state IDLE, all outputs 0, pending flags 0, counters 0.
- Reset mid-PRESENT drops `done` immediately, without waiting for `clk`.
- All outputs are registered.
- Paired latency: quat and gyro pulses at cycle t → pending at t+1 → `done` = 1 and snapshot valid at t+2.
- Unpaired latency: first pulse at t → `done` at t+2+`GATHER_CYCLES`.
- Acknowledge latency: `load` rising edge sampled at t → `done` = 0 at t+`SYNC_STAGES`+1.
- Next `done` is no earlier than `HOLDOFF_CYCLES`+1 cycles after it falls.
- Timeout: `done` is high for exactly `ACK_TIMEOUT` cycles.

## Structure
- Package `sensor_pkt_pkg`:
  - `quat_t` struct {w, x, y, z: logic signed [15:0]}.
  - `gyro_t` struct {x, y, z}.
  - `sched_state_t` enum.
  - `PKT_HEADER` = 8'hAA.
  - `PKT_BYTES` = 16.
- Sub-module `sync_rise_detect` (parameter `STAGES`): flop chain plus rising-edge pulse on `load`.
- The rest is in one module with one FSM `always_ff`.

## Test plan
Bench parameters: `GATHER_CYCLES`=8, `ACK_TIMEOUT`=50, `HOLDOFF_CYCLES`=4, `SYNC_STAGES`=2.
1. Quat (w=16'h4000) and gyro (x=-5) pulse on the same cycle t → `done` at t+2; snap_quat_w=16'h4000, snap_gyro_x=16'hFFFB, both valids=1, `seq`=1; `load` rises → `done`=0 three cycles later.
2. Quat only, no gyro → `done` at t+10 with `snap_quat_valid`=1 and `snap_gyro_valid`=0.
3. Three quat pulses during PRESENT (values 1, 2, 3) → `drop_cnt`=2; snapshot unchanged until acknowledge; next snapshot quat_w=3.
4. No `load` → `done` falls after 50 cycles and `timeout_flag`=1; the next acknowledged snapshot clears `timeout_flag`.
5. 300 forced drops → `drop_cnt` holds 255. 257 snapshots → `seq`=1.
6. Assert `rst_n`=0 mid-PRESENT, asynchronously → `done`, `seq` and flags are 0 immediately; after reset a `load` edge with nothing pending causes no transition.
